// File: rtl/fifo_sync_fwft_pkg.sv
// Shared definitions for the synchronous FIFO family.
//  - Default word width and address width.
//  - Read-mode encodings: FIFO_MODE_STD (registered read), FIFO_MODE_FWFT
//    (first-word-fall-through).
//  - fifo_thresh_ok(): the legal almost-full/almost-empty threshold range,
//    evaluated at elaboration time.
package fifo_sync_fwft_pkg;

  localparam int FIFO_DEF_DATA_WIDTH = 8;
  localparam int FIFO_DEF_ADDR_WIDTH = 4;

  localparam bit FIFO_MODE_STD  = 1'b0;
  localparam bit FIFO_MODE_FWFT = 1'b1;

  function automatic bit fifo_thresh_ok(input int depth, input int afull, input int aempty);
    return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty < depth);
  endfunction

endpackage

// File: rtl/fifo_sync_fwft_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH storage for the synchronous FIFO.
//  clk    in  rising-edge clock
//  we     in  write enable (synchronous write)
//  waddr  in  write address
//  wdata  in  write data
//  raddr  in  read address (asynchronous read)
//  rdata  out read data, mem[raddr]
// Contents are deliberately not reset.
module fifo_mem
  import fifo_sync_fwft_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_fwft.sv
// fifo_sync_fwft: parameterised single-clock FIFO with optional
// first-word-fall-through read, occupancy count, programmable almost flags,
// synchronous flush and sticky overflow/underflow.
//  clk, rst              clock, synchronous active-high reset
//  flush                 synchronous clear of contents (error flags kept)
//  wr_en, din            push request and data
//  rd_en                 pop request
//  dout, dout_valid      read data and its qualifier
//  full, empty           count == DEPTH / count == 0
//  almost_full/_empty    count >= AFULL_THRESH / count <= AEMPTY_THRESH
//  count                 occupancy 0..DEPTH
//  overflow, underflow   sticky: a push / pop was rejected
module fifo_sync_fwft
  import fifo_sync_fwft_pkg::*;
#(
  parameter int DATA_WIDTH    = FIFO_DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = FIFO_DEF_ADDR_WIDTH,
  parameter bit FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] ONE_C   = PW'(1);

  generate
    if (!fifo_thresh_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_param_chk
      $error("fifo_sync_fwft: AFULL_THRESH/AEMPTY_THRESH out of range");
    end
  endgenerate

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags come straight off the registered count so they move on the same
  // edge as the pointers.
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    // flush masks both requests, so nothing moves and no error is flagged.
    rd_acc      = rd_en & ~empty & ~flush;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is ok.
    wr_acc      = wr_en & (~full | rd_acc) & ~flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
      if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_C;
      overflow_d  = overflow_q  | (wr_en & ~wr_acc);
      underflow_d = underflow_q | (rd_en & ~rd_acc);
    end
    count_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (din),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is presented directly; forced to 0 when empty so dout is
      // deterministic after reset/flush even though memory is not cleared.
      assign dout       = empty ? '0 : mem_rdata;
      assign dout_valid = ~empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q, dout_d;
      logic                  dout_valid_q, dout_valid_d;

      always_comb begin
        dout_d       = rd_acc ? mem_rdata : dout_q;
        dout_valid_d = rd_acc;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
        end else begin
          dout_q       <= dout_d;
          dout_valid_q <= dout_valid_d;
        end
      end

      assign dout       = dout_q;
      assign dout_valid = dout_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_fwft.sv
module tb_fifo_sync_fwft;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] s_dout, f_dout;
  logic       s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] s_count, f_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: a queue of words plus the two sticky flags and the
  // registered-read output of the standard mode.
  logic [7:0] mq[$];
  bit         m_ovf, m_udf, m_sdv;
  logic [7:0] m_sdout;

  always #5 clk = ~clk;

  fifo_sync_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .dout_valid(s_dv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf));

  fifo_sync_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf));

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit pop, push;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_sdv = 0; m_sdout = 8'h00;
    end else if (flush) begin
      mq.delete();
      m_sdv = 0;
    end else begin
      pop  = rd_en && (mq.size() > 0);
      push = wr_en && ((mq.size() < 16) || pop);
      if (wr_en && !push) m_ovf = 1;
      if (rd_en && !pop)  m_udf = 1;
      m_sdv = pop;
      if (pop)  m_sdout = mq.pop_front();
      if (push) mq.push_back(din);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic f, input logic [7:0] d);
    wr_en = w; rd_en = r; flush = f; din = d;
    @(posedge clk);
    model_edge();
    #1;
    wr_en = 0; rd_en = 0; flush = 0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    rst = 1'b0;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = mq.size();
      cmp("count_std",  32'(s_count), 32'(n));
      cmp("count_fwft", 32'(f_count), 32'(n));
      cmp("empty_std",  32'(s_empty), 32'(n == 0));
      cmp("empty_fwft", 32'(f_empty), 32'(n == 0));
      cmp("full_std",   32'(s_full),  32'(n == 16));
      cmp("full_fwft",  32'(f_full),  32'(n == 16));
      cmp("afull_std",  32'(s_af),    32'(n >= 14));
      cmp("afull_fwft", 32'(f_af),    32'(n >= 14));
      cmp("aempty_std", 32'(s_ae),    32'(n <= 2));
      cmp("aempty_fwft",32'(f_ae),    32'(n <= 2));
      cmp("ovf_std",    32'(s_ovf),   32'(m_ovf));
      cmp("ovf_fwft",   32'(f_ovf),   32'(m_ovf));
      cmp("udf_std",    32'(s_udf),   32'(m_udf));
      cmp("udf_fwft",   32'(f_udf),   32'(m_udf));
      cmp("dout_std",   32'(s_dout),  32'(m_sdout));
      cmp("dv_std",     32'(s_dv),    32'(m_sdv));
      cmp("dout_fwft",  32'(f_dout),  32'((n > 0) ? mq[0] : 8'h00));
      cmp("dv_fwft",    32'(f_dv),    32'(n > 0));
    end
  end

  initial begin
    // 1. reset values
    do_rst();
    chk_en = 1'b1;
    cmp("t1_count",   32'(s_count), 0);
    cmp("t1_empty",   32'({s_empty, f_empty}), 32'h3);
    cmp("t1_aempty",  32'({s_ae, f_ae}), 32'h3);
    cmp("t1_full",    32'({s_full, f_full}), 0);
    cmp("t1_err",     32'({s_ovf, s_udf, f_ovf, f_udf}), 0);
    cmp("t1_dout",    32'({s_dout, f_dout}), 0);
    cmp("t1_dv",      32'({s_dv, f_dv}), 0);

    // 2. fill 0x00..0x0F, almost_full edge at 14, then drain in order
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 8'(i));
      if (i == 12) cmp("t2_af_at13", 32'({s_af, f_af}), 0);
      if (i == 13) cmp("t2_af_at14", 32'({s_af, f_af}), 32'h3);
    end
    cmp("t2_full",  32'({s_full, f_full}), 32'h3);
    cmp("t2_count", 32'(s_count), 16);
    for (int i = 0; i < 16; i++) begin
      cmp("t2_fwft_head", 32'(f_dout), 32'(i));
      step(0, 1, 0, 8'h00);
      cmp("t2_std_rd", 32'({s_dv, s_dout}), 32'(9'h100 | i));
    end
    cmp("t2_empty", 32'({s_empty, f_empty}), 32'h3);

    // 3. simultaneous push/pop while full, then a rejected push
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(8'h10 + i));
    step(1, 1, 0, 8'hAA);
    cmp("t3_count", 32'(s_count), 16);
    cmp("t3_popped", 32'(s_dout), 32'h10);
    step(1, 0, 0, 8'hEE);
    cmp("t3_ovf", 32'({s_ovf, f_ovf}), 32'h3);
    cmp("t3_head", 32'(f_dout), 32'h11);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00);
    cmp("t3_last", 32'(s_dout), 32'hAA);

    // 4. pop on empty, then push+pop on empty
    step(0, 1, 0, 8'h00);
    cmp("t4_udf", 32'({s_udf, f_udf}), 32'h3);
    cmp("t4_count", 32'(f_count), 0);
    step(1, 1, 0, 8'h33);
    cmp("t4_count1", 32'(s_count), 1);
    cmp("t4_udf_kept", 32'({s_udf, f_udf}), 32'h3);

    // 5. write into empty FIFO: fall-through vs. registered read
    do_rst();
    step(1, 0, 0, 8'h5A);
    cmp("t5_fwft", 32'({f_dv, f_dout}), 32'h15A);
    cmp("t5_std_idle", 32'(s_dv), 0);
    step(0, 1, 0, 8'h00);
    cmp("t5_std_rd", 32'({s_dv, s_dout}), 32'h15A);
    step(0, 0, 0, 8'h00);
    cmp("t5_std_hold", 32'({s_dv, s_dout}), 32'h05A);

    // 6. flush beats same-cycle requests and keeps error flags
    step(0, 1, 0, 8'h00);              // underflow on empty
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'hC0 + i));
    step(1, 1, 1, 8'h77);
    cmp("t6_count", 32'(s_count), 0);
    cmp("t6_empty", 32'({s_empty, f_empty}), 32'h3);
    cmp("t6_flags", 32'({s_ovf, s_udf}), 32'h1);
    cmp("t6_dv", 32'({s_dv, f_dv}), 0);

    // wrap: 40 interleaved writes/reads, then drain
    for (int i = 0; i < 40; i++) step(1, (i >= 3), 0, 8'(i * 7 + 1));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);

    // reset mid-transfer discards data
    for (int i = 0; i < 6; i++) step(1, 0, 0, 8'(8'h90 + i));
    do_rst();
    cmp("t7_rst_empty", 32'({s_empty, f_empty, s_count}), 32'h60);

    step(0, 0, 0, 8'h00);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
